// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: opcodes, instruction field
// positions and the small decode helpers used by decode and the ALU bench.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int INST_W = 16;
    localparam int REG_AW = 3;
    localparam int OP_W   = 4;
    localparam int IMM_W  = 6;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_SLT  = 4'h5;
    localparam logic [OP_W-1:0] OP_SHF  = 4'h6;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h9;
    localparam logic [OP_W-1:0] OP_LDI  = 4'hA;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'hB;
    localparam logic [OP_W-1:0] OP_BNE  = 4'hC;

    // Field LSB positions; branches reuse the rd/rs1 slots for rs1/rs2.
    localparam int OP_LSB     = 12;
    localparam int RD_LSB     = 9;
    localparam int RS1_LSB    = 6;
    localparam int RS2_LSB    = 3;
    localparam int DIR_BIT    = 2;
    localparam int IMM_LSB    = 0;
    localparam int BR_RS1_LSB = 9;
    localparam int BR_RS2_LSB = 6;

    function automatic logic is_rtype(input logic [OP_W-1:0] op);
        return op <= OP_SHF;
    endfunction

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic writes_rd(input logic [OP_W-1:0] op);
        return is_rtype(op) || (op == OP_ADDI) || (op == OP_LDI);
    endfunction

    function automatic logic uses_rs1(input logic [OP_W-1:0] op);
        return is_rtype(op) || (op == OP_ADDI) || is_branch(op);
    endfunction

    function automatic logic uses_rs2(input logic [OP_W-1:0] op);
        return is_rtype(op) || is_branch(op);
    endfunction

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/id_decode_stage_regfile.sv
// 8x8 register file: two asynchronous read ports, one synchronous write
// port, R0 hardwired to zero, asynchronous clear.
module regfile
    import cpu_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem [NREGS];

    // Write port; R0 is never written so it always reads back zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/id_decode_stage.sv
// Decode stage: instruction decode, register read with writeback bypass,
// one-bubble load-use hazard stall, execute pipeline register with flush,
// and a saturating count of hazard-stall cycles.
module id_decode_stage
    import cpu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [OP_W-1:0]   ex_opcode,
    output logic              ex_dir,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_we,
    output logic [DATA_W-1:0] ex_br_off,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [OP_W-1:0]   op;
    logic              br;
    logic [REG_AW-1:0] rd_fld;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;
    logic              hazard;
    logic              xfer;

    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic [DATA_W-1:0] dec_off;
    logic              dec_dir;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_we;

    assign op     = in_inst[OP_LSB +: OP_W];
    assign br     = is_branch(op);
    assign rd_fld = in_inst[RD_LSB +: REG_AW];
    assign imm    = sext_imm(in_inst[IMM_LSB +: IMM_W]);

    // Branches carry their sources one field higher than R-type/ADDI.
    assign src1 = br ? in_inst[BR_RS1_LSB +: REG_AW] : in_inst[RS1_LSB +: REG_AW];
    assign src2 = br ? in_inst[BR_RS2_LSB +: REG_AW] : in_inst[RS2_LSB +: REG_AW];

    regfile #(.NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (src1),
        .rdata1 (rf_rd1),
        .raddr2 (src2),
        .rdata2 (rf_rd2)
    );

    // A writeback in flight is forwarded so reads never see stale data.
    assign opnd1 = (wb_en && (wb_rd == src1) && (src1 != '0)) ? wb_data : rf_rd1;
    assign opnd2 = (wb_en && (wb_rd == src2) && (src2 != '0)) ? wb_data : rf_rd2;

    // ex_we already excludes rd=0, so R0 sources never trigger a stall.
    assign hazard = ex_valid && ex_we &&
                    ((uses_rs1(op) && (ex_rd == src1)) ||
                     (uses_rs2(op) && (ex_rd == src2)));

    assign in_ready = !hazard && (!ex_valid || ex_ready);
    assign xfer     = in_valid && in_ready;

    // Operand and control decode; unknown opcodes fall out as zeroed NOPs.
    always_comb begin
        dec_a   = '0;
        dec_b   = '0;
        dec_off = '0;
        dec_dir = 1'b0;
        dec_rd  = '0;
        dec_we  = 1'b0;
        if (uses_rs1(op)) dec_a = opnd1;
        if (uses_rs2(op)) begin
            dec_b = opnd2;
        end else if ((op == OP_ADDI) || (op == OP_LDI)) begin
            dec_b = imm;
        end
        if (br) dec_off = imm;
        if (op == OP_SHF) dec_dir = in_inst[DIR_BIT];
        if (writes_rd(op)) begin
            dec_rd = rd_fld;
            dec_we = (rd_fld != '0);
        end
    end

    // Execute register: flush beats load, load beats drain, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_opcode <= '0;
            ex_dir    <= 1'b0;
            ex_rd     <= '0;
            ex_we     <= 1'b0;
            ex_br_off <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (xfer) begin
            ex_valid  <= 1'b1;
            ex_a      <= dec_a;
            ex_b      <= dec_b;
            ex_opcode <= op;
            ex_dir    <= dec_dir;
            ex_rd     <= dec_rd;
            ex_we     <= dec_we;
            ex_br_off <= dec_off;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // Saturating count of cycles where a presented instruction is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
